// File: rtl/udp_buf_pkg.sv
// Shared types and constants for the UDP packet-buffer controller.
package udp_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_e;

  localparam int DEF_DATA_W = 64;
  // The eop flag rides in the RAM word just above the payload.
  localparam int EOP_BIT    = DEF_DATA_W;

endpackage

// File: rtl/ram.sv
// Simple dual-port RAM: clocked write port, combinational read port.
module ram #(
  parameter int addr_width = 10,
  parameter int data_width = 65
) (
  input  logic                  wr_clk,
  input  logic                  wr_ena,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_clk,
  input  logic                  rd_ena,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] mem [2**addr_width];

  // The read port is asynchronous, so its clock has no function here.
  logic unused_rd_clk;
  assign unused_rd_clk = rd_clk;

  // NOTE: the storage array has no reset; clearing a RAM costs a full sweep
  // and the pointers already define which entries are meaningful.
  always_ff @(posedge wr_clk) begin
    if (wr_ena) mem[wr_addr] <= wr_data;
  end

  assign rd_data = rd_ena ? mem[rd_addr] : '0;

endmodule

// File: rtl/udp_pkt_buf_ctrl.sv
// Circular frame store: speculative frame writes committed on eop, whole-frame
// drop with pointer rewind on overflow, zero-latency valid/ready read side.
module udp_pkt_buf_ctrl
  import udp_buf_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eop,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              drop_pulse
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  wr_state_e          state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_com_q, wr_com_d;
  logic [PTR_W-1:0]   wr_cur_q, wr_cur_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               drop_pulse_q, drop_pulse_d;

  logic [PTR_W-1:0]   base;
  logic               sop_start;
  logic               commit;
  logic [1:0]         drop_n;
  logic               wr_ena;
  logic [DATA_W:0]    rd_data;
  logic               rd_fire;
  logic [CNT_W:0]     drop_sum;

  // Occupancy is measured against the pre-advance read head, so a read in the
  // same cycle never rescues a write.
  function automatic logic is_full(input logic [PTR_W-1:0] wp,
                                   input logic [PTR_W-1:0] rp);
    logic [PTR_W-1:0] used;
    used = wp - rp;
    return used == DEPTH;
  endfunction

  // NOTE: every signal gets a default at the top of the block so that no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    wr_cur_d  = wr_cur_q;
    wr_com_d  = wr_com_q;
    base      = wr_cur_q;
    sop_start = 1'b0;
    commit    = 1'b0;
    drop_n    = 2'd0;
    wr_ena    = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        ST_IDLE: sop_start = in_sop;
        ST_DROP: begin
          if (in_sop)      sop_start = 1'b1;
          else if (in_eop) state_d   = ST_IDLE;
        end
        ST_WRITE: begin
          if (in_sop) begin
            // Unterminated frame: discard it, then restart on this sop.
            drop_n    = 2'd1;
            base      = wr_com_q;
            wr_cur_d  = wr_com_q;
            sop_start = 1'b1;
          end else if (is_full(wr_cur_q, rd_ptr_q)) begin
            wr_cur_d = wr_com_q;
            drop_n   = 2'd1;
            state_d  = in_eop ? ST_IDLE : ST_DROP;
          end else begin
            wr_ena   = 1'b1;
            wr_cur_d = wr_cur_q + 1'b1;
            if (in_eop) begin
              wr_com_d = wr_cur_q + 1'b1;
              commit   = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (sop_start) begin
        if (is_full(base, rd_ptr_q)) begin
          drop_n  = drop_n + 2'd1;
          state_d = in_eop ? ST_IDLE : ST_DROP;
        end else begin
          wr_ena   = 1'b1;
          wr_cur_d = base + 1'b1;
          if (in_eop) begin
            wr_com_d = base + 1'b1;
            commit   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_WRITE;
          end
        end
      end
    end
  end

  ram #(
    .addr_width (ADDR_W),
    .data_width (DATA_W + 1)
  ) u_ram (
    .wr_clk  (clk),
    .wr_ena  (wr_ena),
    .wr_addr (base[ADDR_W-1:0]),
    .wr_data ({in_eop, in_data}),
    .rd_clk  (clk),
    .rd_ena  (1'b1),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  assign out_valid = (rd_ptr_q != wr_com_q);
  assign out_data  = rd_data[DATA_W-1:0];
  assign out_eop   = rd_data[EOP_BIT];
  assign rd_fire   = out_valid & out_ready;

  always_comb begin
    rd_ptr_d     = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    frame_cnt_d  = frame_cnt_q + CNT_W'(commit) - CNT_W'(rd_fire & out_eop);
    drop_sum     = {1'b0, drop_cnt_q} + (CNT_W + 1)'(drop_n);
    drop_cnt_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    drop_pulse_d = (drop_n != 2'd0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_ptr_q     <= '0;
      wr_com_q     <= '0;
      wr_cur_q     <= '0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_com_q     <= wr_com_d;
      wr_cur_q     <= wr_cur_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign drop_pulse = drop_pulse_q;

endmodule
